frontend: RTL and testbench
===========================

// Module: frontend
// PURPOSE
//  RV32I fetch/decode/sequencing stage feeding backend. Holds the PC and fetches from the instruction ROM.
//  Decodes into active-LOW one-hot alu_op/mem_op plus operands, and resolves branches from backend flags.
//  Two-state FSM (FETCH, EXEC) gives CPI = 2; GPR write strobe is issued in EXEC.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset
//  TRAP_PC    32'h0000_0100  PC taken on illegal instruction (only with FRONTEND_TRAP_EN)
// PORTS
//  clk        in   1   system clock, rising edge
//  rst_n      in   1   asynchronous, active-LOW reset
//  imem_addr  out  32  ROM address (= pc)
//  imem_data  in   32  ROM instruction word, valid by end of FETCH
//  rs1_addr   out  5   GPR read port a index
//  rs2_addr   out  5   GPR read port b index
//  rs1_data   in   32  GPR port a data
//  rs2_data   in   32  GPR port b data
//  rd_addr    out  5   GPR write index
//  gpr_we_n   out  1   GPR write enable, active LOW; backend's gpr_di is the write data
//  alu_op     out  8   {slt,sltu,sll,srl,sra,381op[2:0]}; bits 7:3 active LOW
//  mem_op     out  8   {sw,sh,sb,lhu,lbu,lw,lh,lb}, active LOW one-hot
//  load       out  1   load instruction, active LOW
//  store      out  1   store instruction, active LOW
//  alu_opr_1  out  32  backend operand a
//  alu_opr_2  out  32  backend operand b
//  mem_di     out  32  store data (= rs2_data)
//  is_lt      in   1   backend signed a<b, active LOW
//  is_ltu     in   1   backend unsigned a<b, active LOW
//  is_zero    in   1   backend a==b, active LOW
//  halt       out  1   HIGH once ECALL/EBREAK has executed
// BEHAVIOUR
//  Reset (async, rst_n LOW):
//   - pc = RESET_PC, state = FETCH, ir = 32'h0000_0013 (NOP)
//   - alu_op = 8'hFB (add), mem_op = 8'hFF, load = store = gpr_we_n = 1, halt = 0
//  FETCH: imem_addr = pc. All strobes inactive: mem_op = 8'hFF, load = store = gpr_we_n = 1.
//   Rising edge latches ir <= imem_data; next state EXEC.
//  EXEC: decode ir combinationally; drive backend and GPR. Rising edge updates pc; next state FETCH.
//  381op codes: add 3'b011, A-B 3'b010, xor 3'b100, or 3'b101, and 3'b110.
//  Shift and slt decodes drive 381op = A-B; unused bits 7:3 are held 1.
//  Operand select:
//   - OP/OP-IMM/branch: opr_1 = rs1, opr_2 = rs2 or sign-extended imm
//   - load/store: opr_1 = rs1 + imm via add
//   - LUI: opr_1 = 0, opr_2 = U-imm
//   - AUIPC: opr_1 = pc, opr_2 = U-imm
//   - JAL/JALR: opr_1 = pc, opr_2 = 4 (link value)
//  Branches: 381op = A-B; gpr_we_n = 1.
//   - taken conditions: BEQ ~is_zero, BNE is_zero, BLT ~is_lt, BGE is_lt, BLTU ~is_ltu, BGEU is_ltu
//  Next PC:
//   - taken branch / JAL: pc + imm (local 32-bit adder, wraps mod 2^32)
//   - JALR: (rs1 + imm) & ~32'h1
//   - otherwise: pc + 4
//  gpr_we_n LOW in EXEC only when rd != 0 and the op writes rd (not branch/store/FENCE).
//  FENCE: NOP.
//  ECALL/EBREAK: enter HALT; pc frozen; strobes inactive; halt = 1. Only rst_n exits HALT.
//  Misaligned PC target is not checked; bits [1:0] go to the ROM as-is.
//  rst_n asserted mid-EXEC: strobes deassert immediately (async). No partial GPR write after release.
// CONFIGURATION
//  FRONTEND_TRAP_EN defined:
//   - unknown opcode/funct in EXEC: no writes, no memory op, next pc = TRAP_PC
//  FRONTEND_TRAP_EN undefined:
//   - unknown encodings execute as NOP (pc + 4)
// STRUCTURE
//  util/_rv32i_defs.vh holds the shared `defines:
//   - opcodes, funct3 codes, 381op codes
//   - ALU_OP_*/MEM_OP_* active-LOW vectors, FSM state codes
//  Sub-module _imm_gen: combinational I/S/B/U/J immediate extraction from ir.
// TESTING
//  1. Reset release, ROM[0] = addi x1,x0,5:
//     FETCH at 0 -> EXEC alu_op = 8'hFB, opr_2 = 5, gpr_we_n = 0, rd = 1 -> pc = 4.
//  2. beq x1,x2,+16 at pc 8 with is_zero = 0 -> pc = 24; with is_zero = 1 -> pc = 12; gpr_we_n stays 1.
//  3. sw x2,4(x1), rs1 = 0x100:
//     EXEC store = 0, mem_op = 8'h7F, opr_1 + opr_2 = 0x104, gpr_we_n = 1.
//  4. jalr x1,3(x5), x5 = 0x200, pc = 0x40:
//     opr_1 = 0x40, opr_2 = 4, gpr_we_n = 0 -> pc = 0x202.
//  5. ebreak -> halt = 1, pc frozen over 10 cycles; rst_n pulse mid-HALT -> pc = RESET_PC, halt = 0.
//  6. Opcode 7'h7F:
//     with FRONTEND_TRAP_EN -> pc = 0x100, no writes; without it -> pc + 4, no writes.

Source files
------------

// File: rtl/frontend_pkg.sv
// rtl/frontend_pkg.sv - RV32I frontend opcodes, funct3 codes, active-low op vectors, FSM states
package frontend_pkg;

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [2:0] OP381_SUB = 3'b010;
    localparam logic [2:0] OP381_ADD = 3'b011;
    localparam logic [2:0] OP381_XOR = 3'b100;
    localparam logic [2:0] OP381_OR  = 3'b101;
    localparam logic [2:0] OP381_AND = 3'b110;

    // {slt,sltu,sll,srl,sra} flags are active LOW, followed by the 381 function code
    localparam logic [7:0] ALU_ADD  = {5'b11111, OP381_ADD};
    localparam logic [7:0] ALU_SUB  = {5'b11111, OP381_SUB};
    localparam logic [7:0] ALU_XOR  = {5'b11111, OP381_XOR};
    localparam logic [7:0] ALU_OR   = {5'b11111, OP381_OR};
    localparam logic [7:0] ALU_AND  = {5'b11111, OP381_AND};
    localparam logic [7:0] ALU_SLT  = {5'b01111, OP381_SUB};
    localparam logic [7:0] ALU_SLTU = {5'b10111, OP381_SUB};
    localparam logic [7:0] ALU_SLL  = {5'b11011, OP381_SUB};
    localparam logic [7:0] ALU_SRL  = {5'b11101, OP381_SUB};
    localparam logic [7:0] ALU_SRA  = {5'b11110, OP381_SUB};

    localparam logic [7:0] MEM_NONE = 8'hFF;
    localparam logic [7:0] MEM_LB   = 8'hFE;
    localparam logic [7:0] MEM_LH   = 8'hFD;
    localparam logic [7:0] MEM_LW   = 8'hFB;
    localparam logic [7:0] MEM_LBU  = 8'hF7;
    localparam logic [7:0] MEM_LHU  = 8'hEF;
    localparam logic [7:0] MEM_SB   = 8'hDF;
    localparam logic [7:0] MEM_SH   = 8'hBF;
    localparam logic [7:0] MEM_SW   = 8'h7F;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    // Backend flags are active LOW: a LOW flag means the relation holds
    function automatic logic branch_taken(input logic [2:0] f3, input logic lt_n,
                                          input logic ltu_n, input logic zero_n);
        case (f3)
            F3_BEQ:  return !zero_n;
            F3_BNE:  return zero_n;
            F3_BLT:  return !lt_n;
            F3_BGE:  return lt_n;
            F3_BLTU: return !ltu_n;
            default: return ltu_n;
        endcase
    endfunction

endpackage

// File: rtl/frontend_imm_gen.sv
// rtl/frontend_imm_gen.sv - I/S/B/U/J immediate extraction from the instruction register
module frontend_imm_gen (
    input  logic [31:0] ir,
    output logic [31:0] imm_i,
    output logic [31:0] imm_s,
    output logic [31:0] imm_b,
    output logic [31:0] imm_u,
    output logic [31:0] imm_j
);

    assign imm_i = {{20{ir[31]}}, ir[31:20]};
    assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_u = {ir[31:12], 12'b0};
    assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

endmodule

// File: rtl/frontend.sv
// rtl/frontend.sv - RV32I fetch/decode/sequencing stage, CPI 2; FRONTEND_TRAP_EN enables illegal-op trap
module frontend
    import frontend_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_PC  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic [4:0]  rd_addr,
    output logic        gpr_we_n,
    output logic [7:0]  alu_op,
    output logic [7:0]  mem_op,
    output logic        load,
    output logic        store,
    output logic [31:0] alu_opr_1,
    output logic [31:0] alu_opr_2,
    output logic [31:0] mem_di,
    input  logic        is_lt,
    input  logic        is_ltu,
    input  logic        is_zero,
    output logic        halt
);

`ifdef FRONTEND_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    state_t      state;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] pc_plus4, pc_next;
    logic [7:0]  mem_sel;
    logic        is_load, is_store, wr_rd, illegal, sys_halt, active;

    wire [6:0] opcode = ir[6:0];
    wire [2:0] funct3 = ir[14:12];
    wire [6:0] funct7 = ir[31:25];

    frontend_imm_gen u_imm_gen (
        .ir    (ir),
        .imm_i (imm_i),
        .imm_s (imm_s),
        .imm_b (imm_b),
        .imm_u (imm_u),
        .imm_j (imm_j)
    );

    assign imem_addr = pc;
    assign rs1_addr  = ir[19:15];
    assign rs2_addr  = ir[24:20];
    assign rd_addr   = ir[11:7];
    assign mem_di    = rs2_data;
    assign pc_plus4  = pc + 32'd4;

    always_comb begin
        alu_op    = ALU_ADD;
        mem_sel   = MEM_NONE;
        is_load   = 1'b0;
        is_store  = 1'b0;
        wr_rd     = 1'b0;
        illegal   = 1'b0;
        sys_halt  = 1'b0;
        alu_opr_1 = rs1_data;
        alu_opr_2 = rs2_data;
        pc_next   = pc_plus4;
        case (opcode)
            OPC_OP_IMM: begin
                alu_opr_2 = imm_i;
                wr_rd     = 1'b1;
                case (funct3)
                    F3_ADD:  alu_op = ALU_ADD;
                    F3_SLT:  alu_op = ALU_SLT;
                    F3_SLTU: alu_op = ALU_SLTU;
                    F3_XOR:  alu_op = ALU_XOR;
                    F3_OR:   alu_op = ALU_OR;
                    F3_AND:  alu_op = ALU_AND;
                    F3_SLL: begin
                        alu_op  = ALU_SLL;
                        illegal = (funct7 != 7'h00);
                    end
                    default: begin
                        alu_op  = funct7[5] ? ALU_SRA : ALU_SRL;
                        illegal = (funct7 != 7'h00) && (funct7 != 7'h20);
                    end
                endcase
            end
            OPC_OP: begin
                wr_rd = 1'b1;
                case (funct3)
                    F3_ADD:  alu_op = funct7[5] ? ALU_SUB : ALU_ADD;
                    F3_SLT:  alu_op = ALU_SLT;
                    F3_SLTU: alu_op = ALU_SLTU;
                    F3_XOR:  alu_op = ALU_XOR;
                    F3_OR:   alu_op = ALU_OR;
                    F3_AND:  alu_op = ALU_AND;
                    F3_SLL:  alu_op = ALU_SLL;
                    default: alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
                endcase
                illegal = !((funct7 == 7'h00) ||
                            ((funct7 == 7'h20) && ((funct3 == F3_ADD) || (funct3 == F3_SR))));
            end
            OPC_LOAD: begin
                alu_opr_2 = imm_i;
                is_load   = 1'b1;
                wr_rd     = 1'b1;
                case (funct3)
                    F3_B:    mem_sel = MEM_LB;
                    F3_H:    mem_sel = MEM_LH;
                    F3_W:    mem_sel = MEM_LW;
                    F3_BU:   mem_sel = MEM_LBU;
                    F3_HU:   mem_sel = MEM_LHU;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_STORE: begin
                alu_opr_2 = imm_s;
                is_store  = 1'b1;
                case (funct3)
                    F3_B:    mem_sel = MEM_SB;
                    F3_H:    mem_sel = MEM_SH;
                    F3_W:    mem_sel = MEM_SW;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_BRANCH: begin
                alu_op = ALU_SUB;
                if ((funct3 == 3'b010) || (funct3 == 3'b011))
                    illegal = 1'b1;
                else if (branch_taken(funct3, is_lt, is_ltu, is_zero))
                    pc_next = pc + imm_b;
            end
            OPC_LUI: begin
                alu_opr_1 = 32'd0;
                alu_opr_2 = imm_u;
                wr_rd     = 1'b1;
            end
            OPC_AUIPC: begin
                alu_opr_1 = pc;
                alu_opr_2 = imm_u;
                wr_rd     = 1'b1;
            end
            OPC_JAL: begin
                alu_opr_1 = pc;
                alu_opr_2 = 32'd4;
                wr_rd     = 1'b1;
                pc_next   = pc + imm_j;
            end
            OPC_JALR: begin
                alu_opr_1 = pc;
                alu_opr_2 = 32'd4;
                wr_rd     = 1'b1;
                illegal   = (funct3 != 3'b000);
                pc_next   = (rs1_data + imm_i) & ~32'h1;
            end
            OPC_MISC_MEM: ;
            OPC_SYSTEM: begin
                // Only ECALL and EBREAK are supported; they differ only in ir[20]
                if ((funct3 == 3'b000) && (ir[31:21] == 11'd0) && (ir[19:7] == 13'd0))
                    sys_halt = 1'b1;
                else
                    illegal = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        if (illegal)
            pc_next = TRAP_EN ? TRAP_PC : pc_plus4;
    end

    // Strobes are gated by the state register, so an async reset drops them at once
    assign active   = (state == S_EXEC) && !illegal && !sys_halt;
    assign mem_op   = (active && (is_load || is_store)) ? mem_sel : MEM_NONE;
    assign load     = !(active && is_load);
    assign store    = !(active && is_store);
    assign gpr_we_n = !(active && wr_rd && (rd_addr != 5'd0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
            pc    <= RESET_PC;
            ir    <= NOP_INSN;
            halt  <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    ir    <= imem_data;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (sys_halt) begin
                        state <= S_HALT;
                        halt  <= 1'b1;
                    end else begin
                        pc    <= pc_next;
                        state <= S_FETCH;
                    end
                end
                default: state <= S_HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_frontend.sv
// tb/tb_frontend.sv - directed self-checking bench for frontend
module tb_frontend;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr, imem_data;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [31:0] rs1_data = 32'd0, rs2_data = 32'd0;
    logic        gpr_we_n, load, store, halt;
    logic [7:0]  alu_op, mem_op;
    logic [31:0] alu_opr_1, alu_opr_2, mem_di;
    logic        is_lt = 1'b1, is_ltu = 1'b1, is_zero = 1'b1;

    logic [31:0] rom [0:255];
    int          n_checks = 0;
    int          n_errors = 0;

    assign imem_data = rom[imem_addr[9:2]];

    always #5 clk = ~clk;

    frontend dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .rd_addr   (rd_addr),
        .gpr_we_n  (gpr_we_n),
        .alu_op    (alu_op),
        .mem_op    (mem_op),
        .load      (load),
        .store     (store),
        .alu_opr_1 (alu_opr_1),
        .alu_opr_2 (alu_opr_2),
        .mem_di    (mem_di),
        .is_lt     (is_lt),
        .is_ltu    (is_ltu),
        .is_zero   (is_zero),
        .halt      (halt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 32'h0000_0013;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        check("rst_addr",  imem_addr, 32'h0);
        check("rst_alu",   alu_op,    8'hFB);
        check("rst_mem",   mem_op,    8'hFF);
        check("rst_strb",  {load, store, gpr_we_n, halt}, 4'b1110);
        rst_n = 1'b1;
    endtask

    initial begin
        // Test 1: addi x1,x0,5 at reset vector, then async reset mid-EXEC
        clear_rom();
        rom[0] = 32'h0050_0093;
        do_reset();
        check("t1_fetch_we", gpr_we_n, 1'b1);
        tick(1);
        check("t1_alu",  alu_op,    8'hFB);
        check("t1_opr2", alu_opr_2, 32'd5);
        check("t1_we",   gpr_we_n,  1'b0);
        check("t1_rd",   rd_addr,   5'd1);
        tick(1);
        check("t1_pc",   imem_addr, 32'd4);
        do_reset();
        tick(1);
        check("t1_exec_we", gpr_we_n, 1'b0);
        #1 rst_n = 1'b0;
        #1 check("t1_async_we", gpr_we_n, 1'b1);
        check("t1_async_pc", imem_addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);
        check("t1_rerun_pc", imem_addr, 32'd4);

        // Test 2: beq x1,x2,+16 at pc 8, taken then not taken
        clear_rom();
        rom[2] = 32'h0020_8863;
        is_zero = 1'b0;
        do_reset();
        tick(5);
        check("t2_alu",   alu_op,   8'hFA);
        check("t2_we",    gpr_we_n, 1'b1);
        tick(1);
        check("t2_taken", imem_addr, 32'd24);
        is_zero = 1'b1;
        do_reset();
        tick(5);
        check("t2_nt_we", gpr_we_n, 1'b1);
        tick(1);
        check("t2_not",   imem_addr, 32'd12);

        // Test 3: sw, sub, slt, lw sequence
        clear_rom();
        rom[0] = 32'h0020_A223;
        rom[1] = 32'h4020_81B3;
        rom[2] = 32'h0020_A1B3;
        rom[3] = 32'h0080_A203;
        rs1_data = 32'h100;
        rs2_data = 32'hDEAD_BEEF;
        do_reset();
        tick(1);
        check("t3_store", store,  1'b0);
        check("t3_load",  load,   1'b1);
        check("t3_mem",   mem_op, 8'h7F);
        check("t3_addr",  alu_opr_1 + alu_opr_2, 32'h104);
        check("t3_we",    gpr_we_n, 1'b1);
        check("t3_di",    mem_di, 32'hDEAD_BEEF);
        tick(1);
        check("t3_fetch_store", {store, mem_op}, 9'h1FF);
        check("t3_pc",    imem_addr, 32'd4);
        tick(1);
        check("t3_sub",   alu_op,   8'hFA);
        check("t3_sub_rd", rd_addr, 5'd3);
        check("t3_sub_we", gpr_we_n, 1'b0);
        tick(2);
        check("t3_slt",   alu_op,   8'h7A);
        tick(2);
        check("t3_lw_mem", mem_op,  8'hFB);
        check("t3_lw_ld",  load,    1'b0);
        check("t3_lw_imm", alu_opr_2, 32'd8);
        check("t3_lw_we",  gpr_we_n, 1'b0);
        tick(1);
        check("t3_end_pc", imem_addr, 32'd16);

        // Test 4: jalr x1,3(x5) at pc 0x40
        clear_rom();
        rom[16] = 32'h0032_80E7;
        rs1_data = 32'h200;
        do_reset();
        tick(32);
        check("t4_at40", imem_addr, 32'h40);
        tick(1);
        check("t4_opr1", alu_opr_1, 32'h40);
        check("t4_opr2", alu_opr_2, 32'd4);
        check("t4_we",   gpr_we_n,  1'b0);
        tick(1);
        check("t4_pc",   imem_addr, 32'h202);

        // Test 5: ebreak at pc 4, then reset out of HALT
        clear_rom();
        rom[1] = 32'h0010_0073;
        do_reset();
        tick(3);
        check("t5_exec_we", gpr_we_n, 1'b1);
        tick(1);
        check("t5_halt", halt, 1'b1);
        tick(10);
        check("t5_frozen", imem_addr, 32'd4);
        check("t5_halt10", halt, 1'b1);
        check("t5_strb", {gpr_we_n, load, store, mem_op}, 11'h7FF);
        #2 rst_n = 1'b0;
        #1 check("t5_rst_halt", halt, 1'b0);
        check("t5_rst_pc", imem_addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);
        check("t5_run_pc", imem_addr, 32'd4);
        check("t5_run_halt", halt, 1'b0);

        // Test 6: unknown opcode 7'h7F with rd = x1
        clear_rom();
        rom[0] = 32'h0000_00FF;
        do_reset();
        tick(1);
        check("t6_we",   gpr_we_n, 1'b1);
        check("t6_mem",  {load, store, mem_op}, 10'h3FF);
        tick(1);
`ifdef FRONTEND_TRAP_EN
        check("t6_pc", imem_addr, 32'h100);
`else
        check("t6_pc", imem_addr, 32'd4);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
